// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter
//   Arbitrates one shared resource among 8 requesters. Two runtime modes:
//   fixed priority (bit 7 highest) or round-robin (rotating pointer,
//   descending search with wrap). The owner keeps the grant while it
//   requests. Its tenure is capped at MAX_HOLD cycles when others are waiting.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   mode_rr   0 = fixed priority, 1 = round-robin
//   req[7:0]  level-sensitive requests
//   gnt[7:0]  one-hot grant (registered)
//   gnt_id    index of granted requester, 0 when idle (registered)
//   gnt_valid high whenever gnt is nonzero (registered)
//   timeout   one-cycle pulse alongside a grant that revoked the previous
//             owner on hold timeout (registered)
module rr_priority_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_rr,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [7:0] count, count_nxt;
  logic [7:0] gnt_nxt;
  logic [2:0] gnt_id_nxt;
  logic       gnt_valid_nxt;
  logic       timeout_nxt;

  logic [2:0] start;
  logic [7:0] others;
  logic [3:0] hit_all;
  logic [3:0] hit_oth;
  logic       load;
  logic [2:0] win;

  // Descending search from 'start' with wrap: start, start-1, ..., start+1.
  // Walk from the farthest candidate to the nearest so the nearest set bit
  // overwrites and wins. Result is {found, index}.
  function automatic logic [3:0] search(input logic [7:0] cand,
                                        input logic [2:0] first);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = first - 3'(i);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // The pointer is maintained in both modes; only the search start depends
  // on the mode, so switching modes never disturbs the current owner.
  assign start   = mode_rr ? ptr : 3'd7;
  assign others  = req & ~(8'b1 << gnt_id);
  assign hit_all = search(req, start);
  assign hit_oth = search(others, start);

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    count_nxt     = count;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    load          = 1'b0;
    win           = 3'd0;

    case (state)
      IDLE: begin
        if (hit_all[3]) begin
          load = 1'b1;
          win  = hit_all[2:0];
        end
      end
      GRANT: begin
        if (req[gnt_id] && ((count < HOLD_MAX) || (others == 8'd0))) begin
          // Owner keeps the grant; count saturates at MAX_HOLD.
          if (count < HOLD_MAX) count_nxt = count + 8'd1;
        end else if (!req[gnt_id]) begin
          // Owner released: hand over in the same cycle, no bubble.
          if (hit_all[3]) begin
            load = 1'b1;
            win  = hit_all[2:0];
          end else begin
            state_nxt     = IDLE;
            gnt_nxt       = 8'd0;
            gnt_id_nxt    = 3'd0;
            gnt_valid_nxt = 1'b0;
            count_nxt     = 8'd0;
          end
        end else begin
          // Tenure exhausted with others waiting: the owner is excluded
          // from this search, so 'others' is nonzero and a winner exists.
          load        = 1'b1;
          win         = hit_oth[2:0];
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      state_nxt     = GRANT;
      gnt_nxt       = 8'b1 << win;
      gnt_id_nxt    = win;
      gnt_valid_nxt = 1'b1;
      count_nxt     = 8'd1;
      ptr_nxt       = win - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd7;
      count     <= 8'd0;
      gnt       <= 8'd0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      count     <= count_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Arbitrates one shared resource among 8 requesters; one-hot grant plus encoded index.
- Runtime-selectable modes: fixed priority (bit 7 highest) or round-robin (rotating pointer, descending search with wrap).
- Registered grant, hold-while-requesting ownership, bounded tenure via hold timeout.
- Sits in front of any shared datapath whose users were previously selected by static 8:3 priority encoding.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles for one owner while other requests are pending; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode_rr  input  1  0 = fixed priority, 1 = round-robin
- req  input  8  request per requester, level-sensitive
- gnt  output  8  one-hot grant, registered
- gnt_id  output  3  index of granted requester, registered
- gnt_valid  output  1  high when gnt is nonzero
- timeout  output  1  one-cycle pulse when a grant is revoked by hold timeout

Behaviour:
- Reset, asynchronous while rst_n=0:
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - State IDLE, ptr=7, hold count=0.
  - A grant in progress is dropped immediately.
- Search function, combinational:
  - Start at start index s and move downward: s, s-1, ..., 0, 7, ..., s+1.
  - The first set bit of the candidate vector wins.
  - s = 7 when mode_rr=0; s = ptr when mode_rr=1.
- State IDLE:
  - If req != 0, search req; at the next edge, load gnt/gnt_id with the winner, set gnt_valid=1 and count=1, and go to GRANT.
  - Latency: req asserted at edge N gives the grant visible after edge N+1.
- State GRANT, owner o:
  - Case a) req[o]=1 and (count < MAX_HOLD or req & ~(1<<o) == 0): keep the grant and increment count, saturating at MAX_HOLD.
  - Case b) req[o]=0: re-arbitrate over req in the same cycle.
    - Winner found: load it next edge, count=1, stay in GRANT. Back-to-back, no bubble.
    - No winner: clear the grant, go to IDLE.
  - Case c) req[o]=1, count == MAX_HOLD, other requests pending: search req & ~(1<<o), load that winner next edge, count=1, pulse timeout for that one cycle.
- ptr update: on every new grant load (IDLE->GRANT, case b, case c) with winner w, ptr <= w-1 mod 8, i.e. 0 -> 7. The update happens in both modes, so switching to RR continues fairly.
- mode_rr may change at any cycle. It affects only the next search and never revokes a current grant.
- Invariants:
  - gnt always has at most one bit set.
  - gnt_valid == |gnt.
  - gnt_id == 0 when gnt_valid=0.
- Requester contract: a requester drops req for at least one cycle to release. The arbiter does not need req to stay high until granted; a withdrawn request simply loses.

Test Plan:
- Reset/idle: rst_n=0 with req=8'hFF -> gnt=0, gnt_valid=0. Release reset with req=0 for 5 cycles -> outputs stay 0.
- Fixed priority: mode_rr=0, req=8'b0010_0110 -> gnt=8'h20, gnt_id=5 one cycle later. Drop req[5] -> next cycle gnt=8'h04, id=2, no bubble. Drop req[2] -> id=1.
- Round-robin fairness: mode_rr=1, req=8'hFF held, each owner dropping req for 1 cycle after 1 grant cycle -> grant order 7,6,5,4,3,2,1,0,7; each requester granted exactly once per 8 grants.
- Hold timeout: MAX_HOLD=16, req[3]=1 constant, req[6] asserted at cycle 4 of tenure -> gnt stays 8'h08 for exactly 16 cycles, then gnt=8'h40 with timeout=1 for one cycle. Repeat with req[6]=0 -> owner 3 keeps grant indefinitely, no timeout.
- Async reset mid-grant: gnt=8'h10 held, rst_n pulsed low between edges -> gnt=0, gnt_valid=0 immediately. After release with req=8'h11 -> gnt=8'h10 (ptr back to 7).
- Mode switch: mode_rr=1, grant 7 completes (ptr=6), switch to mode_rr=0 with req=8'h81 -> gnt=8'h80. Switch back to RR and repeat -> gnt=8'h01 (ptr=6, search 6..0 finds bit 0 before wrapping to 7).
